// File: rtl/copro_issue_scheduler.sv
// Issue/retire controller for the CV-X-IF example coprocessor: forwards the predecoder
// verdict as the issue response and retires accepted instructions in order.
module copro_issue_scheduler #(
  parameter int unsigned Depth    = 4,
  parameter int unsigned IdWidth  = 4,
  parameter int unsigned LatWidth = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [IdWidth-1:0]  issue_id_i,
  input  logic                dec_accept_i,
  input  logic                dec_writeback_i,
  input  logic [LatWidth-1:0] dec_latency_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  input  logic                commit_valid_i,
  input  logic [IdWidth-1:0]  commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [IdWidth-1:0]  result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic                busy_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW-1:0] FullOcc = OccW'(Depth);

  logic [Depth-1:0]    vld_q, vld_d, we_q, we_d, com_q, com_d, kil_q, kil_d;
  logic [IdWidth-1:0]  id_q [Depth];
  logic [IdWidth-1:0]  id_d [Depth];
  logic [4:0]          rdst_q [Depth];
  logic [4:0]          rdst_d [Depth];
  logic [LatWidth-1:0] cnt_q [Depth];
  logic [LatWidth-1:0] cnt_d [Depth];
  logic [PtrW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [OccW-1:0]     occ_q, occ_d;
  logic                push, pop, full, head_done, res_vld, dup_id;
  logic                unused_instr;

  assign unused_instr = ^{issue_instr_i[31:12], issue_instr_i[6:0]};

  assign full              = (occ_q == FullOcc);
  assign issue_ready_o     = !full;
  assign issue_accept_o    = issue_valid_i & dec_accept_i;
  assign issue_writeback_o = issue_accept_o & dec_writeback_i;
  assign push              = issue_accept_o & issue_ready_o;

  // Retirement looks only at the registered head entry, so result_valid_o never depends on result_ready_i.
  assign head_done = vld_q[head_q] & com_q[head_q] & (cnt_q[head_q] == '0);
  assign res_vld   = head_done & !kil_q[head_q] & we_q[head_q];
  assign pop       = vld_q[head_q] & (kil_q[head_q] | (head_done & (!we_q[head_q] | result_ready_i)));

  assign result_valid_o = res_vld;
  assign result_we_o    = res_vld;
  assign result_id_o    = res_vld ? id_q[head_q] : '0;
  assign result_rd_o    = res_vld ? rdst_q[head_q] : '0;
  assign busy_o         = (occ_q != '0);

  always_comb begin
    vld_d  = vld_q;
    we_d   = we_q;
    com_d  = com_q;
    kil_d  = kil_q;
    id_d   = id_q;
    rdst_d = rdst_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < Depth; i++) begin
      if (vld_q[i] && (cnt_q[i] != '0)) cnt_d[i] = cnt_q[i] - LatWidth'(1);
      if (vld_q[i] && commit_valid_i && (id_q[i] == commit_id_i)) begin
        if (commit_kill_i) kil_d[i] = 1'b1;
        else               com_d[i] = 1'b1;
      end
    end
    if (pop) vld_d[head_q] = 1'b0;
    // A commit/kill that arrives with its own issue is folded into the new entry.
    if (push) begin
      vld_d[tail_q]  = 1'b1;
      id_d[tail_q]   = issue_id_i;
      rdst_d[tail_q] = issue_instr_i[11:7];
      we_d[tail_q]   = dec_writeback_i;
      cnt_d[tail_q]  = dec_latency_i;
      com_d[tail_q]  = commit_valid_i & !commit_kill_i & (commit_id_i == issue_id_i);
      kil_d[tail_q]  = commit_valid_i & commit_kill_i & (commit_id_i == issue_id_i);
    end
    head_d = head_q + PtrW'(pop);
    tail_d = tail_q + PtrW'(push);
    occ_d  = occ_q + OccW'(push) - OccW'(pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q  <= '0;
      we_q   <= '0;
      com_q  <= '0;
      kil_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      for (int i = 0; i < Depth; i++) begin
        id_q[i]   <= '0;
        rdst_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      we_q   <= we_d;
      com_q  <= com_d;
      kil_q  <= kil_d;
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      id_q   <= id_d;
      rdst_q <= rdst_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    dup_id = 1'b0;
    for (int i = 0; i < Depth; i++)
      for (int j = i + 1; j < Depth; j++)
        if (vld_q[i] && vld_q[j] && (id_q[i] == id_q[j])) dup_id = 1'b1;
  end

  // Duplicate in-flight ids make commit/kill ambiguous; flagged but not fatal.
  assert property (@(posedge clk_i) disable iff (rst_i) !dup_id)
    else $warning("copro_issue_scheduler: two in-flight entries share an id");

endmodule
